// File: rtl/dmem_banked.sv
// Byte-addressable data memory behind a single-outstanding valid/ready request/response
// port with a fixed response latency, byte-lane stores and sign/zero-extended loads.
module dmem_banked #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  o_dbg_state
);

   // Handshake: a request transfers on a rising edge with req_valid && req_ready; a
   // response stays valid with stable data/err until a rising edge with rsp_ready.

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [1:0]  CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_cnt;
   logic [1:0]  w_cnt_next;

   logic        r_we;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_from_idle;
   logic          w_we;
   logic [31:0]   w_addr;
   logic [1:0]    w_size;
   logic          w_uns;
   logic [31:0]   w_wdata;
   logic          w_err;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_be;
   logic [31:0]   w_wd;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;

   assign req_ready   = rst && (r_state == S_IDLE);
   assign rsp_valid   = rst && (r_state == S_RESP);
   assign rsp_rdata   = rsp_valid ? r_rdata : 32'd0;
   assign rsp_err     = rsp_valid && r_err;
   assign o_dbg_state = r_state;
   assign w_accept    = req_valid && req_ready;

   // With LATENCY=1 RESP is entered on the accepting edge, so the live request is used.
   assign w_from_idle = (r_state == S_IDLE);
   assign w_we        = w_from_idle ? req_we       : r_we;
   assign w_addr      = w_from_idle ? req_addr     : r_addr;
   assign w_size      = w_from_idle ? req_size     : r_size;
   assign w_uns       = w_from_idle ? req_unsigned : r_uns;
   assign w_wdata     = w_from_idle ? req_wdata    : r_wdata;

   assign w_err = (w_size == 2'b11)
                || ((w_size == 2'b01) && w_addr[0])
                || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
                || ({1'b0, w_addr} >= LIMIT);
   assign w_idx  = w_addr[AW+1:2];
   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_be   = 4'b1111;
      w_wd   = w_wdata;
      w_load = w_word;
      case (w_size)
         2'b00: begin
            w_be   = 4'b0001 << w_addr[1:0];
            w_wd   = {4{w_wdata[7:0]}};
            w_load = {{24{~w_uns & w_byte[7]}}, w_byte};
         end
         2'b01: begin
            w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wd   = {2{w_wdata[15:0]}};
            w_load = {{16{~w_uns & w_half[15]}}, w_half};
         end
         default: begin
            w_be   = 4'b1111;
            w_wd   = w_wdata;
            w_load = w_word;
         end
      endcase
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (!rst) begin
         w_next     = S_IDLE;
         w_cnt_next = 2'd0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               w_cnt_next = CNT_INIT;
               w_next     = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: if (r_cnt == 2'd0) w_next = S_RESP;
                    else w_cnt_next = r_cnt - 2'd1;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

   always_ff @(posedge clk) begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_size  <= req_size;
         r_uns   <= req_unsigned;
         r_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_enter_resp) begin
         r_err   <= w_err;
         r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      end
   end

   // Memory is deliberately outside reset; a reset edge never enters RESP, so it never writes.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
         end
      end
   end

endmodule
